// File: rtl/multi_track_loop_ctrl.sv
// ---------------------------------------------------------------------------
// multi_track_loop_ctrl
//   Multi-track audio looper controller. The first recording sets the master
//   loop length. Later tracks are overdubbed phase-locked to that loop, one
//   loop pass at a time. The block drives the shared sample address and the
//   per-track record/play enables for the track memories.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   sample_tick   one-cycle strobe per audio sample (address advance)
//   rec_req       per-track record button pulses (lowest index wins)
//   play_req      global run/stop toggle pulse
//   clear_req     erase all tracks and the loop length
//   addr          shared sample address
//   loop_len      captured loop length in samples (0 = none)
//   rec_en        per-track write enable (at most one bit set)
//   play_en       per-track read enable
//   track_valid   per-track "holds content" flags
//   wrap          one-cycle pulse on the tick where addr returns to 0
//   led_rec       any track recording
//   led_play      loop running
// ---------------------------------------------------------------------------
module multi_track_loop_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic [NUM_TRACKS-1:0] rec_req,
  input  logic                  play_req,
  input  logic                  clear_req,
  output logic [ADDR_W-1:0]     addr,
  output logic [ADDR_W:0]       loop_len,
  output logic [NUM_TRACKS-1:0] rec_en,
  output logic [NUM_TRACKS-1:0] play_en,
  output logic [NUM_TRACKS-1:0] track_valid,
  output logic                  wrap,
  output logic                  led_rec,
  output logic                  led_play
);

  typedef enum logic [1:0] {S_EMPTY, S_REC_MASTER, S_RUN, S_STOP} state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W:0]       loop_len_q, loop_len_d;
  logic [NUM_TRACKS-1:0] master_q, master_d;   // one-hot master track
  logic [NUM_TRACKS-1:0] arm_q, arm_d;         // one-hot armed overdub track
  logic [NUM_TRACKS-1:0] rec_en_q, rec_en_d;
  logic [NUM_TRACKS-1:0] play_en_q, play_en_d;
  logic [NUM_TRACKS-1:0] valid_q, valid_d;
  logic                  wrap_q, wrap_d;
  logic                  led_rec_q, led_rec_d;
  logic                  led_play_q, led_play_d;

  logic [NUM_TRACKS-1:0] sel;          // lowest set bit of rec_req
  logic                  at_end;       // addr is the last sample of the loop
  logic                  auto_stop;    // master recording fills the address space
  logic [ADDR_W:0]       master_len;   // samples recorded including this tick

  // NOTE: every variable below gets a default before the case so no path
  // leaves one unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    loop_len_d = loop_len_q;
    master_d   = master_q;
    arm_d      = arm_q;
    rec_en_d   = rec_en_q;
    valid_d    = valid_q;
    wrap_d     = 1'b0;
    sel        = rec_req & (~rec_req + NUM_TRACKS'(1));
    at_end     = ({1'b0, addr_q} == loop_len_q - (ADDR_W+1)'(1));
    auto_stop  = sample_tick && (addr_q == ADDR_MAX);
    master_len = {1'b0, addr_q} + (ADDR_W+1)'(sample_tick);

    if (clear_req) begin
      state_d    = S_EMPTY;
      addr_d     = '0;
      loop_len_d = '0;
      master_d   = '0;
      arm_d      = '0;
      rec_en_d   = '0;
      valid_d    = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          // play_req outranks rec_req; it is ignored here but still blocks it.
          if (!play_req && sel != '0) begin
            state_d  = S_REC_MASTER;
            master_d = sel;
            addr_d   = '0;
            rec_en_d = sel;
          end
        end

        S_REC_MASTER: begin
          if (play_req) begin
            state_d  = S_EMPTY;
            addr_d   = '0;
            master_d = '0;
            rec_en_d = '0;
          end else begin
            if (sample_tick) addr_d = addr_q + ADDR_W'(1);
            if ((sel & master_q) != '0 || auto_stop) begin
              rec_en_d = '0;
              addr_d   = '0;
              if (master_len == '0) begin
                state_d = S_EMPTY;
              end else begin
                state_d    = S_RUN;
                loop_len_d = master_len;
                valid_d    = master_q;
                wrap_d     = auto_stop;
              end
            end
          end
        end

        S_RUN: begin
          if (play_req) begin
            // A running overdub keeps what it has written so far.
            state_d  = S_STOP;
            arm_d    = '0;
            valid_d  = valid_q | rec_en_q;
            rec_en_d = '0;
          end else begin
            if (sample_tick) begin
              addr_d = at_end ? '0 : addr_q + ADDR_W'(1);
              if (at_end) begin
                wrap_d   = 1'b1;
                valid_d  = valid_q | rec_en_q;   // finished pass
                rec_en_d = arm_q;                // armed track starts at addr 0
                arm_d    = '0;
              end
            end
            // Requests are judged against the registered arm/record state so
            // a request landing on a wrap cannot start a recording early.
            if (sel != '0) begin
              if (arm_q == '0 && rec_en_q == '0) begin
                arm_d = sel;
              end else if ((sel & arm_q) != '0) begin
                arm_d    = '0;
                rec_en_d = rec_en_d & ~sel;
              end else if ((sel & rec_en_q) != '0) begin
                rec_en_d = '0;
                valid_d  = valid_d | sel;
              end
            end
          end
        end

        S_STOP: begin
          if (play_req) begin
            state_d = S_RUN;
            addr_d  = '0;
          end
        end

        default: state_d = S_EMPTY;
      endcase
    end

    play_en_d  = (state_d == S_RUN) ? valid_d : '0;
    led_rec_d  = |rec_en_d;
    led_play_d = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      addr_q     <= '0;
      loop_len_q <= '0;
      master_q   <= '0;
      arm_q      <= '0;
      rec_en_q   <= '0;
      play_en_q  <= '0;
      valid_q    <= '0;
      wrap_q     <= 1'b0;
      led_rec_q  <= 1'b0;
      led_play_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      loop_len_q <= loop_len_d;
      master_q   <= master_d;
      arm_q      <= arm_d;
      rec_en_q   <= rec_en_d;
      play_en_q  <= play_en_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      led_rec_q  <= led_rec_d;
      led_play_q <= led_play_d;
    end
  end

  assign addr        = addr_q;
  assign loop_len    = loop_len_q;
  assign rec_en      = rec_en_q;
  assign play_en     = play_en_q;
  assign track_valid = valid_q;
  assign wrap        = wrap_q;
  assign led_rec     = led_rec_q;
  assign led_play    = led_play_q;

endmodule

// File: tb/tb_multi_track_loop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_track_loop_ctrl
//   Directed bench for multi_track_loop_ctrl (NUM_TRACKS=4, ADDR_W=4).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_multi_track_loop_ctrl;

  localparam int NT = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic [NT-1:0] rec_req = '0;
  logic          play_req = 1'b0;
  logic          clear_req = 1'b0;
  logic [AW-1:0] addr;
  logic [AW:0]   loop_len;
  logic [NT-1:0] rec_en, play_en, track_valid;
  logic          wrap, led_rec, led_play;

  int checks = 0;
  int failures = 0;

  multi_track_loop_ctrl #(.NUM_TRACKS(NT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rec_req(rec_req),
    .play_req(play_req), .clear_req(clear_req), .addr(addr), .loop_len(loop_len),
    .rec_en(rec_en), .play_en(play_en), .track_valid(track_valid), .wrap(wrap),
    .led_rec(led_rec), .led_play(led_play)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given input pulses.
  task automatic step(input logic tick, input logic [NT-1:0] rec,
                      input logic play, input logic clr);
    sample_tick = tick;
    rec_req     = rec;
    play_req    = play;
    clear_req   = clr;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    rec_req     = '0;
    play_req    = 1'b0;
    clear_req   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"},  addr, 0);
    check({tag, "_len"},   loop_len, 0);
    check({tag, "_rec"},   rec_en, 0);
    check({tag, "_play"},  play_en, 0);
    check({tag, "_valid"}, track_valid, 0);
    check({tag, "_wrap"},  wrap, 0);
    check({tag, "_lrec"},  led_rec, 0);
    check({tag, "_lplay"}, led_play, 0);
  endtask

  initial begin
    // ---- 1. reset, master on track 1, 5 samples ----
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");

    step(1'b0, 4'b0010, 1'b0, 1'b0);
    check("t1_rec_start", rec_en, 4'b0010);
    check("t1_lrec", led_rec, 1);
    check("t1_addr0", addr, 0);
    ticks(5);
    check("t1_addr5", addr, 5);
    check("t1_len_pending", loop_len, 0);
    step(1'b0, 4'b0010, 1'b0, 1'b0);
    check("t1_len", loop_len, 5);
    check("t1_valid", track_valid, 4'b0010);
    check("t1_play_en", play_en, 4'b0010);
    check("t1_rec_off", rec_en, 0);
    check("t1_run", led_play, 1);
    check("t1_addr_restart", addr, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, '0, 1'b0, 1'b0);
      check($sformatf("t1_cyc_addr%0d", i), addr, i % 5);
      check($sformatf("t1_cyc_wrap%0d", i), wrap, (i % 5 == 0) ? 1 : 0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_wrap_pulse", wrap, 0);

    // ---- 3. overdub track 0 armed at addr 2 ----
    ticks(2);
    check("t3_addr2", addr, 2);
    step(1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("t3_armed_rec%0d", i), rec_en, 0);
      step(1'b1, '0, 1'b0, 1'b0);
    end
    check("t3_wrap", wrap, 1);
    check("t3_rec_start", rec_en, 4'b0001);
    check("t3_rec_addr0", addr, 0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, '0, 1'b0, 1'b0);
      check($sformatf("t3_rec%0d", i), rec_en, (i < 5) ? 1 : 0);
    end
    check("t3_valid", track_valid, 4'b0011);
    check("t3_play_en", play_en, 4'b0011);
    check("t3_lrec_off", led_rec, 0);

    // ---- 4. arm 0, foreign request ignored, disarm ----
    step(1'b0, 4'b0001, 1'b0, 1'b0);
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 1'b0);
    ticks(5);
    check("t4_wrap", wrap, 1);
    check("t4_no_rec", rec_en, 0);
    check("t4_valid", track_valid, 4'b0011);

    // ---- 5. stop at addr 3, restart ----
    ticks(3);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t5_stop_addr", addr, 3);
    check("t5_stop_play", play_en, 0);
    check("t5_stop_rec", rec_en, 0);
    check("t5_stop_led", led_play, 0);
    ticks(2);
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    check("t5_hold_addr", addr, 3);
    check("t5_stop_ignore_rec", rec_en, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t5_restart_addr", addr, 0);
    check("t5_restart_play", play_en, 4'b0011);
    check("t5_restart_led", led_play, 1);

    // ---- 6. clear+play mid overdub, zero-length master ----
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    ticks(5);
    check("t6_rec_start", rec_en, 4'b0100);
    ticks(2);
    check("t6_rec_addr", addr, 2);
    step(1'b0, '0, 1'b1, 1'b1);
    check_idle("t6_clear");
    step(1'b0, '0, 1'b1, 1'b0);
    check("t6_empty_play_ignored", led_play, 0);
    step(1'b0, 4'b0110, 1'b0, 1'b0);
    check("t6_lowest_idx", rec_en, 4'b0010);
    step(1'b0, 4'b0010, 1'b0, 1'b0);
    check_idle("t6_zero_len");

    // ---- 2. auto-stop at full address space ----
    step(1'b0, 4'b1000, 1'b0, 1'b0);
    ticks(15);
    check("t2_addr15", addr, 15);
    check("t2_len_pending", loop_len, 0);
    check("t2_still_rec", rec_en, 4'b1000);
    step(1'b1, '0, 1'b0, 1'b0);
    check("t2_len", loop_len, 16);
    check("t2_addr0", addr, 0);
    check("t2_valid", track_valid, 4'b1000);
    check("t2_rec_off", rec_en, 0);
    check("t2_run", led_play, 1);
    ticks(15);
    check("t2_run_addr15", addr, 15);
    check("t2_run_nowrap", wrap, 0);
    step(1'b1, '0, 1'b0, 1'b0);
    check("t2_run_addr_wrap", addr, 0);
    check("t2_run_wrap", wrap, 1);

    // ---- async reset during master recording ----
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 4'b0001, 1'b0, 1'b0);
    ticks(3);
    #2 rst = 1'b1;
    #1;
    check_idle("arst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_stays_empty", loop_len, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
